// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared types for the memory-controller arbiter slice.
// Block address/data widths match the main-memory controller link.
package mem_ctrl_arbiter_pkg;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    typedef logic [25:0]  main_mem_block_addr_t;
    typedef logic [511:0] block_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_ctrl_arbiter_rr_arbiter.sv
// Combinational grant picker: fixed priority or round-robin from ptr.
// The pointer itself lives in the parent.
module mem_ctrl_arbiter_rr_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = 1,
    parameter int PW   = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    function automatic int slot(input int k, input logic [PW-1:0] p);
        return (MODE != 0) ? ((int'(p) + k) % N) : k;
    endfunction

    // Scan from the far end so the nearest candidate is written last.
    always_comb begin
        grant_idx    = '0;
        any          = 1'b0;
        grant_onehot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[slot(k, ptr)]) begin
                grant_idx = PW'(slot(k, ptr));
                any       = 1'b1;
            end
        end
        if (any) begin
            grant_onehot = N'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// N-channel arbiter sharing one main-memory controller port.
// One block transaction in flight; responses routed back to the owner.
module mem_ctrl_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int ADDR_W   = 26,
    parameter int DATA_W   = 512,
    parameter int ARB_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst_aH,
    input  logic [N_CH-1:0]          ch_req_valid,
    output logic [N_CH-1:0]          ch_req_ready,
    input  logic [N_CH-1:0]          ch_req_type,
    input  logic [N_CH*ADDR_W-1:0]   ch_req_block_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_req_block_data,
    input  logic [N_CH-1:0]          ch_flush,
    output logic [N_CH-1:0]          ch_resp_valid,
    output logic [DATA_W-1:0]        ch_resp_block_data,
    output logic                     mem_req_valid,
    output logic                     mem_req_type,
    output logic [ADDR_W-1:0]        mem_req_block_addr,
    output logic [DATA_W-1:0]        mem_req_block_data,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [DATA_W-1:0]        mem_resp_block_data,
    output logic                     busy
);

    localparam int PW = ptr_w(N_CH);

    arb_state_t        r_state;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     r_owner;
    logic              r_drop;
    req_type_t         r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic [N_CH-1:0]   w_elig;
    logic [N_CH-1:0]   w_gnt_oh;
    logic [PW-1:0]     w_gnt_idx;
    logic              w_any;
    logic              w_owner_flush;
    logic              w_resp_hit;

    assign w_elig        = ch_req_valid & ~ch_flush;
    assign w_owner_flush = ch_flush[r_owner];
    assign w_resp_hit    = (r_state == WAIT) && mem_resp_valid;

    mem_ctrl_arbiter_rr_arbiter #(
        .N    (N_CH),
        .MODE (ARB_MODE),
        .PW   (PW)
    ) u_arb (
        .req          (w_elig),
        .ptr          (r_rr_ptr),
        .grant_onehot (w_gnt_oh),
        .grant_idx    (w_gnt_idx),
        .any          (w_any)
    );

    assign ch_req_ready       = (r_state == IDLE) ? w_gnt_oh : '0;
    assign mem_req_valid      = (r_state == REQ);
    assign mem_req_type       = r_type;
    assign mem_req_block_addr = r_addr;
    assign mem_req_block_data = r_data;
    assign busy               = (r_state != IDLE);
    assign ch_resp_block_data = w_resp_hit ? mem_resp_block_data : '0;

    always_comb begin
        ch_resp_valid = '0;
        if (w_resp_hit && !r_drop && !w_owner_flush) begin
            ch_resp_valid[r_owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_drop   <= 1'b0;
            r_type   <= REQ_READ;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_type   <= req_type_t'(ch_req_type[w_gnt_idx]);
                        r_addr   <= ch_req_block_addr[w_gnt_idx*ADDR_W +: ADDR_W];
                        r_data   <= ch_req_block_data[w_gnt_idx*DATA_W +: DATA_W];
                        r_owner  <= w_gnt_idx;
                        r_drop   <= 1'b0;
                        r_rr_ptr <= (w_gnt_idx == PW'(N_CH - 1)) ? '0
                                                                 : w_gnt_idx + 1'b1;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    if (w_owner_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // The request is never retracted; a flushed reply is absorbed.
                    if (w_owner_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench: 2-channel round-robin and fixed-priority instances share
// stimulus; a 4-channel round-robin instance covers pointer wrap.
module tb_mem_ctrl_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0]    v = '0, ty = '0, f = '0;
    logic [25:0]   a0 = '0, a1 = '0;
    logic [511:0]  d0 = '0, d1 = '0, rd = '0;
    logic          mr = 1'b0, rv = 1'b0;

    logic [1:0]    rdy, rdy0, rsv, rsv0;
    logic [511:0]  rsd, rsd0, md, md0;
    logic [25:0]   ma, ma0;
    logic          mv, mv0, mt, mt0, bz, bz0;

    logic [3:0]    v4 = '0, f4 = '0, ty4 = '0;
    logic [31:0]   a4 = {8'h33, 8'h22, 8'h11, 8'h00};
    logic [63:0]   d4 = '0;
    logic [15:0]   rd4 = 16'h5A5A;
    logic          mr4 = 1'b0, rv4 = 1'b0;
    logic [3:0]    rdy4, rsv4;
    logic [15:0]   rsd4, md4;
    logic [7:0]    ma4;
    logic          mv4, mt4, bz4;

    mem_ctrl_arbiter #(.N_CH(2), .ADDR_W(26), .DATA_W(512), .ARB_MODE(1)) dut (
        .clk(clk), .rst_aH(rst),
        .ch_req_valid(v), .ch_req_ready(rdy), .ch_req_type(ty),
        .ch_req_block_addr({a1, a0}), .ch_req_block_data({d1, d0}),
        .ch_flush(f), .ch_resp_valid(rsv), .ch_resp_block_data(rsd),
        .mem_req_valid(mv), .mem_req_type(mt), .mem_req_block_addr(ma),
        .mem_req_block_data(md), .mem_req_ready(mr),
        .mem_resp_valid(rv), .mem_resp_block_data(rd), .busy(bz)
    );

    mem_ctrl_arbiter #(.N_CH(2), .ADDR_W(26), .DATA_W(512), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst_aH(rst),
        .ch_req_valid(v), .ch_req_ready(rdy0), .ch_req_type(ty),
        .ch_req_block_addr({a1, a0}), .ch_req_block_data({d1, d0}),
        .ch_flush(f), .ch_resp_valid(rsv0), .ch_resp_block_data(rsd0),
        .mem_req_valid(mv0), .mem_req_type(mt0), .mem_req_block_addr(ma0),
        .mem_req_block_data(md0), .mem_req_ready(mr),
        .mem_resp_valid(rv), .mem_resp_block_data(rd), .busy(bz0)
    );

    mem_ctrl_arbiter #(.N_CH(4), .ADDR_W(8), .DATA_W(16), .ARB_MODE(1)) dut4 (
        .clk(clk), .rst_aH(rst),
        .ch_req_valid(v4), .ch_req_ready(rdy4), .ch_req_type(ty4),
        .ch_req_block_addr(a4), .ch_req_block_data(d4),
        .ch_flush(f4), .ch_resp_valid(rsv4), .ch_resp_block_data(rsd4),
        .mem_req_valid(mv4), .mem_req_type(mt4), .mem_req_block_addr(ma4),
        .mem_req_block_data(md4), .mem_req_ready(mr4),
        .mem_resp_valid(rv4), .mem_resp_block_data(rd4), .busy(bz4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn4(input logic [3:0] req, input logic [3:0] exp,
                        input logic [7:0] exp_addr);
        v4 = req;
        #1 chk("n4_grant", rdy4, exp);
        tick;
        v4 = '0;
        chk("n4_req_valid", mv4, 1'b1);
        chk("n4_req_addr", ma4, exp_addr);
        chk("n4_req_type", mt4, 1'b0);
        chk("n4_req_data", md4, 16'h0);
        mr4 = 1'b1;
        tick;
        mr4 = 1'b0;
        rv4 = 1'b1;
        #1 chk("n4_resp", rsv4, exp);
        chk("n4_resp_data", rsd4, 16'h5A5A);
        tick;
        rv4 = 1'b0;
        #1 chk("n4_idle", bz4, 1'b0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_busy", bz, 1'b0);
        chk("rst_busy0", bz0, 1'b0);
        chk("rst_mem_valid", mv, 1'b0);
        chk("rst_ready", rdy, 2'b00);
        chk("rst_resp", rsv, 2'b00);
        chk("rst_addr", ma, 26'h0);
        rst = 1'b0;
        tick;

        // single read on ch0
        v  = 2'b01;
        a0 = 26'h12;
        #1 chk("rd_grant", rdy, 2'b01);
        chk("rd_grant_fp", rdy0, 2'b01);
        tick;
        v = 2'b00;
        #1 chk("rd_mem_valid", mv, 1'b1);
        chk("rd_mem_addr", ma, 26'h12);
        chk("rd_mem_type", mt, 1'b0);
        chk("rd_busy", bz, 1'b1);
        tick;
        mr = 1'b1;
        tick;
        mr = 1'b0;
        #1 chk("rd_wait_novalid", mv, 1'b0);
        tick;
        tick;
        rv = 1'b1;
        rd = {64{8'hAB}};
        #1 chk("rd_resp", rsv, 2'b01);
        chk("rd_resp_data", rsd, {64{8'hAB}});
        chk("rd_resp_data_fp", rsd0, {64{8'hAB}});
        tick;
        rv = 1'b0;
        #1 chk("rd_idle", bz, 1'b0);
        chk("rd_idle_fp", bz0, 1'b0);
        chk("rd_resp_end", rsv, 2'b00);

        // grant order with both channels always requesting
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] e;
            e = (i % 2 == 0) ? 2'b01 : 2'b10;
            v = 2'b11;
            #1 chk("rr_grant", rdy, e);
            chk("fp_grant", rdy0, 2'b01);
            tick;
            v = 2'b00;
            mr = 1'b1;
            tick;
            mr = 1'b0;
            rv = 1'b1;
            #1 chk("rr_resp", rsv, e);
            chk("fp_resp", rsv0, 2'b01);
            tick;
            rv = 1'b0;
        end

        // ch1 write
        v  = 2'b10;
        ty = 2'b10;
        a1 = 26'h30;
        d1 = {32{16'hDEAD}};
        #1 chk("wr_grant", rdy, 2'b10);
        tick;
        v  = 2'b00;
        ty = 2'b00;
        a1 = 26'h0;
        d1 = '0;
        #1 chk("wr_valid", mv, 1'b1);
        chk("wr_type", mt, 1'b1);
        chk("wr_addr", ma, 26'h30);
        chk("wr_data", md, {32{16'hDEAD}});
        chk("wr_valid_fp", mv0, 1'b1);
        chk("wr_type_fp", mt0, 1'b1);
        chk("wr_addr_fp", ma0, 26'h30);
        chk("wr_data_fp", md0, {32{16'hDEAD}});
        tick;
        chk("wr_hold_addr", ma, 26'h30);
        chk("wr_hold_data", md, {32{16'hDEAD}});
        chk("wr_hold_valid", mv, 1'b1);
        mr = 1'b1;
        tick;
        mr = 1'b0;
        #1 chk("wr_wait_busy", bz, 1'b1);
        rv = 1'b1;
        #1 chk("wr_resp", rsv, 2'b10);
        tick;
        rv = 1'b0;

        // flush owner in WAIT
        v = 2'b01;
        tick;
        v = 2'b00;
        mr = 1'b1;
        tick;
        mr = 1'b0;
        f = 2'b01;
        tick;
        f = 2'b00;
        tick;
        rv = 1'b1;
        #1 chk("fl_drop", rsv, 2'b00);
        tick;
        rv = 1'b0;
        #1 chk("fl_idle", bz, 1'b0);
        v = 2'b10;
        #1 chk("fl_next_grant", rdy, 2'b10);
        tick;
        v = 2'b00;
        mr = 1'b1;
        tick;
        mr = 1'b0;
        rv = 1'b1;
        #1 chk("fl_next_resp", rsv, 2'b10);
        tick;
        rv = 1'b0;

        // flush in the response cycle
        v = 2'b01;
        tick;
        v = 2'b00;
        mr = 1'b1;
        tick;
        mr = 1'b0;
        rv = 1'b1;
        f = 2'b01;
        #1 chk("fl_same_cycle", rsv, 2'b00);
        tick;
        rv = 1'b0;
        f = 2'b00;
        #1 chk("fl_same_idle", bz, 1'b0);

        // flushed channel is not eligible in IDLE
        v = 2'b11;
        f = 2'b01;
        #1 chk("fl_blocks", rdy, 2'b10);
        chk("fl_blocks_fp", rdy0, 2'b10);
        tick;
        v = 2'b00;
        f = 2'b00;
        mr = 1'b1;
        tick;
        mr = 1'b0;
        rv = 1'b1;
        #1 chk("fl_blocks_resp", rsv, 2'b10);
        tick;
        rv = 1'b0;

        // stray responses in IDLE and REQ
        rv = 1'b1;
        #1 chk("idle_resp", rsv, 2'b00);
        tick;
        rv = 1'b0;
        #1 chk("idle_stay", bz, 1'b0);
        v = 2'b01;
        tick;
        v = 2'b00;
        rv = 1'b1;
        #1 chk("req_resp", rsv, 2'b00);
        tick;
        rv = 1'b0;
        #1 chk("req_stay", mv, 1'b1);
        mr = 1'b1;
        tick;
        mr = 1'b0;
        rv = 1'b1;
        #1 chk("req_then_resp", rsv, 2'b01);
        tick;
        rv = 1'b0;

        // reset while waiting
        v = 2'b01;
        tick;
        v = 2'b00;
        mr = 1'b1;
        tick;
        mr = 1'b0;
        rst = 1'b1;
        #1 chk("rst_async", bz, 1'b0);
        tick;
        rst = 1'b0;
        rv = 1'b1;
        #1 chk("rst_stale", rsv, 2'b00);
        tick;
        rv = 1'b0;
        #1 chk("rst_stale_busy", bz, 1'b0);
        v = 2'b10;
        #1 chk("rst_after_grant", rdy, 2'b10);
        tick;
        v = 2'b00;
        mr = 1'b1;
        tick;
        mr = 1'b0;
        rv = 1'b1;
        #1 chk("rst_after_resp", rsv, 2'b10);
        tick;
        rv = 1'b0;

        // 4 channels: park rr_ptr at 3 then exercise wrap
        txn4(4'b0100, 4'b0100, 8'h22);
        txn4(4'b1100, 4'b1000, 8'h33);
        txn4(4'b1100, 4'b0100, 8'h22);
        txn4(4'b0011, 4'b0001, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
